// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and constants for the byte-serialising memory arbiter.
//   state_t  : arbiter FSM states (IDLE, four byte beats, response).
//   req_id_t : identity of the requester that owns the current transaction.
//   BYTES_PER_WORD : beats per word transaction.
package mem_arbiter_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    BEAT2 = 3'd3,
    BEAT3 = 3'd4,
    RESP  = 3'd5
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch port, the data port and the byte-wide memory port.
//   Modport slave  : the arbiter's view (takes requests, drives the memory).
//   Modport master : the environment's view (CPU ports plus memory array).
//   Fetch : f_req, f_addr -> f_gnt, f_rvalid, f_rdata
//   Data  : d_req, d_we, d_addr, d_wdata, d_mask -> d_gnt, d_rvalid, d_rdata
//   Memory: mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (one cycle later)
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 12
);

  logic                      f_req;
  logic [AW-1:0]             f_addr;
  logic                      f_gnt;
  logic                      f_rvalid;
  logic [N-1:0]              f_rdata;

  logic                      d_req;
  logic                      d_we;
  logic [AW-1:0]             d_addr;
  logic [N-1:0]              d_wdata;
  logic [BYTES_PER_WORD-1:0] d_mask;
  logic                      d_gnt;
  logic                      d_rvalid;
  logic [N-1:0]              d_rdata;

  logic                      mem_en;
  logic                      mem_we;
  logic [AW-1:0]             mem_addr;
  logic [7:0]                mem_wdata;
  logic [7:0]                mem_rdata;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_mask,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output d_req, d_we, d_addr, d_wdata, d_mask,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/word_serializer.sv
// word_serializer
//   Turns one latched word transaction into four byte beats on the memory
//   port (MSB at the lowest address) and reassembles read bytes into a word.
//   clk, rst     : clock, synchronous active-low reset (control only)
//   beat_act     : a beat is being issued this cycle
//   beat_idx     : beat number k (0..3)
//   rd           : transaction is a read
//   addr/wdata/mask : latched transaction fields
//   mem_rdata    : byte returned by memory one cycle after a read beat
//   mem_en/mem_we/mem_addr/mem_wdata : memory-side strobes, zero when idle
//   word         : assembled read word; complete in the cycle after beat 3
module word_serializer
  import mem_arbiter_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 12
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      beat_act,
  input  logic [1:0]                beat_idx,
  input  logic                      rd,
  input  logic [AW-1:0]             addr,
  input  logic [N-1:0]              wdata,
  input  logic [BYTES_PER_WORD-1:0] mask,
  input  logic [7:0]                mem_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [7:0]                mem_wdata,
  output logic [N-1:0]              word
);

  // Byte k of a word counts from the most significant end.
  function automatic logic [7:0] byte_of(input logic [N-1:0] w, input logic [1:0] k);
    byte_of = w[(N-1) - 8*k -: 8];
  endfunction

  function automatic logic [N-1:0] put_byte(input logic [N-1:0] w, input logic [1:0] k,
                                            input logic [7:0] b);
    logic [N-1:0] r;
    r = w;
    r[(N-1) - 8*k -: 8] = b;
    return r;
  endfunction

  logic [1:0]   msk_sel;
  logic         cap_vld_p1;
  logic [1:0]   cap_idx_p1;
  logic [N-1:0] asm_q;

  // Stage p0: issue the beat. mask[3] belongs to beat 0.
  always_comb begin
    msk_sel   = 2'd3 - beat_idx;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (beat_act) begin
      mem_addr = addr + AW'(beat_idx);
      if (rd) begin
        mem_en = 1'b1;
      end else begin
        mem_en    = mask[msk_sel];
        mem_we    = mask[msk_sel];
        mem_wdata = byte_of(wdata, beat_idx);
      end
    end
  end

  // Stage p1: memory returns the byte; remember which slot it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_vld_p1 <= 1'b0;
    end else begin
      cap_vld_p1 <= beat_act && rd;
    end
  end

  always_ff @(posedge clk) begin
    cap_idx_p1 <= beat_idx;
    asm_q      <= word;
  end

  // The returning byte is merged combinationally so that the final byte of
  // beat 3 is already part of the word in the response cycle.
  always_comb begin
    word = asm_q;
    if (cap_vld_p1) begin
      word = put_byte(asm_q, cap_idx_p1, mem_rdata);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a byte-wide single-port memory between the instruction-fetch and
//   data ports of a CPU. Each 32-bit transaction is serialised into four byte
//   beats; simultaneous requests are arbitrated round-robin.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-low reset
//   bus : mem_arbiter_if.slave (fetch port, data port, memory port)
//   Timing: accept at T, beats T+1..T+4, rvalid at T+5, next accept possible
//   at T+5.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 12
)
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t                    state_q, state_d;
  req_id_t                   last_q, own_q, win;
  logic                      accept;
  logic                      we_q;
  logic [AW-1:0]             addr_q;
  logic [N-1:0]              wdata_q;
  logic [BYTES_PER_WORD-1:0] mask_q;
  logic                      beat_act;
  logic [1:0]                beat_idx;
  logic                      resp;
  logic                      f_rvalid, d_rvalid;
  logic [N-1:0]              word;

  // Accept only in IDLE/RESP and never while reset is asserted, so a request
  // held through reset waits for the first cycle with rst high.
  always_comb begin
    accept = rst && (state_q == IDLE || state_q == RESP) && (bus.f_req || bus.d_req);
    if (bus.f_req && bus.d_req) begin
      win = (last_q == DATA) ? FETCH : DATA;
    end else if (bus.f_req) begin
      win = FETCH;
    end else begin
      win = DATA;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? BEAT0 : IDLE;
      BEAT0:   state_d = BEAT1;
      BEAT1:   state_d = BEAT2;
      BEAT2:   state_d = BEAT3;
      BEAT3:   state_d = RESP;
      RESP:    state_d = accept ? BEAT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_act = 1'b0;
    beat_idx = 2'd0;
    case (state_q)
      BEAT0:   begin beat_act = 1'b1; beat_idx = 2'd0; end
      BEAT1:   begin beat_act = 1'b1; beat_idx = 2'd1; end
      BEAT2:   begin beat_act = 1'b1; beat_idx = 2'd2; end
      BEAT3:   begin beat_act = 1'b1; beat_idx = 2'd3; end
      default: begin beat_act = 1'b0; beat_idx = 2'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= DATA;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= win;
      end
    end
  end

  // Stage p0: latch the winning request; fetch is always a full read.
  always_ff @(posedge clk) begin
    if (accept) begin
      own_q <= win;
      if (win == FETCH) begin
        addr_q  <= bus.f_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
        mask_q  <= '0;
      end else begin
        addr_q  <= bus.d_addr;
        we_q    <= bus.d_we;
        wdata_q <= bus.d_wdata;
        mask_q  <= bus.d_mask;
      end
    end
  end

  word_serializer #(
    .N  (N),
    .AW (AW)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .beat_act  (beat_act),
    .beat_idx  (beat_idx),
    .rd        (!we_q),
    .addr      (addr_q),
    .wdata     (wdata_q),
    .mask      (mask_q),
    .mem_rdata (bus.mem_rdata),
    .mem_en    (bus.mem_en),
    .mem_we    (bus.mem_we),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .word      (word)
  );

  // Response stage: rdata is forced to zero outside the owner's rvalid, and
  // a data write completes with a zero word.
  always_comb begin
    resp         = (state_q == RESP);
    f_rvalid     = resp && (own_q == FETCH);
    d_rvalid     = resp && (own_q == DATA);
    bus.f_gnt    = accept && (win == FETCH);
    bus.d_gnt    = accept && (win == DATA);
    bus.f_rvalid = f_rvalid;
    bus.d_rvalid = d_rvalid;
    bus.f_rdata  = f_rvalid ? word : '0;
    bus.d_rdata  = (d_rvalid && !we_q) ? word : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a byte-wide synchronous memory model.
//   Memory preload: byte[i] = i[7:0], except 0x010..0x013 = 11 22 33 44.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N(32), .AW(12)) bus ();

  mem_arbiter #(.N(32), .AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:4095];
  bit         init_done;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
      mem[12'h010] <= 8'h11;
      mem[12'h011] <= 8'h22;
      mem[12'h012] <= 8'h33;
      mem[12'h013] <= 8'h44;
      init_done    <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  wr_byte [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic        wr_en   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [11:0] wrap_a  [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_fgnt"},   32'(bus.f_gnt),     32'd0);
    chk({tag, "_dgnt"},   32'(bus.d_gnt),     32'd0);
    chk({tag, "_frv"},    32'(bus.f_rvalid),  32'd0);
    chk({tag, "_drv"},    32'(bus.d_rvalid),  32'd0);
    chk({tag, "_men"},    32'(bus.mem_en),    32'd0);
    chk({tag, "_mwe"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_maddr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mwdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_frdata"}, bus.f_rdata,        32'd0);
    chk({tag, "_drdata"}, bus.d_rdata,        32'd0);
  endtask

  // Inputs change 2 time units after the rising edge, checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_mask  = '0;

    // Reset state
    repeat (3) cyc();
    #1;
    chk_quiet("reset");

    // Fetch read at 0x010
    cyc();
    rst = 1'b1; bus.f_req = 1'b1; bus.f_addr = 12'h010;
    #1;
    chk("fetch_fgnt", 32'(bus.f_gnt), 32'd1);
    chk("fetch_dgnt", 32'(bus.d_gnt), 32'd0);
    chk("fetch_men_T", 32'(bus.mem_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.f_req = 1'b0; bus.f_addr = 12'hABC;
      #1;
      chk("fetch_maddr", 32'(bus.mem_addr), 32'h010 + 32'(k));
      chk("fetch_men", 32'(bus.mem_en), 32'd1);
      chk("fetch_mwe", 32'(bus.mem_we), 32'd0);
    end
    cyc(); #1;
    chk("fetch_frv", 32'(bus.f_rvalid), 32'd1);
    chk("fetch_rdata", bus.f_rdata, 32'h11223344);
    chk("fetch_drv", 32'(bus.d_rvalid), 32'd0);
    chk("fetch_men_resp", 32'(bus.mem_en), 32'd0);
    cyc(); #1;
    chk("fetch_frv_after", 32'(bus.f_rvalid), 32'd0);
    chk("fetch_rdata_after", bus.f_rdata, 32'd0);

    // Masked write AABBCCDD at 0x100, mask 1010
    cyc();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h100;
    bus.d_wdata = 32'hAABBCCDD; bus.d_mask = 4'b1010;
    #1;
    chk("wr_dgnt", 32'(bus.d_gnt), 32'd1);
    chk("wr_fgnt", 32'(bus.f_gnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.d_req = 1'b0; bus.d_wdata = 32'h0; bus.d_mask = 4'hF;
      #1;
      chk("wr_maddr", 32'(bus.mem_addr), 32'h100 + 32'(k));
      chk("wr_men", 32'(bus.mem_en), 32'(wr_en[k]));
      chk("wr_mwe", 32'(bus.mem_we), 32'(wr_en[k]));
      chk("wr_mwdata", 32'(bus.mem_wdata), 32'(wr_byte[k]));
    end
    cyc(); #1;
    chk("wr_drv", 32'(bus.d_rvalid), 32'd1);
    chk("wr_drdata", bus.d_rdata, 32'd0);
    chk("wr_frv", 32'(bus.f_rvalid), 32'd0);
    chk("wr_mem100", 32'(mem[12'h100]), 32'hAA);
    chk("wr_mem101", 32'(mem[12'h101]), 32'h01);
    chk("wr_mem102", 32'(mem[12'h102]), 32'hCC);
    chk("wr_mem103", 32'(mem[12'h103]), 32'h03);

    // Wrap-around read at 0xFFE
    cyc();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'hFFE; bus.d_mask = 4'h0;
    #1;
    chk("wrap_dgnt", 32'(bus.d_gnt), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.d_req = 1'b0;
      #1;
      chk("wrap_maddr", 32'(bus.mem_addr), 32'(wrap_a[k]));
      chk("wrap_men", 32'(bus.mem_en), 32'd1);
    end
    cyc(); #1;
    chk("wrap_drv", 32'(bus.d_rvalid), 32'd1);
    chk("wrap_drdata", bus.d_rdata, 32'hFEFF0001);

    // Conflict: both requests held through reset and afterwards
    cyc();
    rst = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 12'h010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'hFFE;
    #1;
    chk_quiet("cfl_rst0");
    cyc(); #1;
    chk_quiet("cfl_rst1");
    for (int t = 0; t < 16; t++) begin
      cyc();
      if (t == 0) rst = 1'b1;
      #1;
      chk("cfl_fgnt", 32'(bus.f_gnt), 32'(t == 0 || t == 10));
      chk("cfl_dgnt", 32'(bus.d_gnt), 32'(t == 5 || t == 15));
      chk("cfl_both", 32'(bus.f_gnt & bus.d_gnt), 32'd0);
      chk("cfl_frv", 32'(bus.f_rvalid), 32'(t == 5 || t == 15));
      chk("cfl_drv", 32'(bus.d_rvalid), 32'(t == 10));
      if (t == 5)  chk("cfl_frdata", bus.f_rdata, 32'h11223344);
      if (t == 10) chk("cfl_drdata", bus.d_rdata, 32'hFEFF0001);
    end
    cyc();
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) cyc();
    cyc(); #1;
    chk("cfl_last_drv", 32'(bus.d_rvalid), 32'd1);
    chk("cfl_last_drdata", bus.d_rdata, 32'hFEFF0001);

    // Reset during a write, at T+2
    cyc();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h200;
    bus.d_wdata = 32'h12345678; bus.d_mask = 4'hF;
    #1;
    chk("abort_dgnt", 32'(bus.d_gnt), 32'd1);
    cyc();
    bus.d_req = 1'b0;
    #1;
    chk("abort_maddr0", 32'(bus.mem_addr), 32'h200);
    chk("abort_mwe0", 32'(bus.mem_we), 32'd1);
    cyc();
    rst = 1'b0;
    #1;
    chk("abort_maddr1", 32'(bus.mem_addr), 32'h201);
    cyc();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h010;
    #1;
    chk_quiet("abort_T3");
    cyc();
    rst = 1'b1;
    #1;
    chk("abort_regnt", 32'(bus.d_gnt), 32'd1);
    chk("abort_drv", 32'(bus.d_rvalid), 32'd0);
    chk("abort_mem200", 32'(mem[12'h200]), 32'h12);
    chk("abort_mem201", 32'(mem[12'h201]), 32'h34);
    chk("abort_mem202", 32'(mem[12'h202]), 32'h02);
    chk("abort_mem203", 32'(mem[12'h203]), 32'h03);
    cyc();
    bus.d_req = 1'b0;
    repeat (3) cyc();
    cyc(); #1;
    chk("abort_next_drv", 32'(bus.d_rvalid), 32'd1);
    chk("abort_next_drdata", bus.d_rdata, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
